cla_wide_add_seq: RTL and testbench

- Multi-cycle wide adder that sits directly upstream of the existing CLA32.
- Accepts WORDS×32-bit operands and a carry-in over a valid/ready handshake.
- Feeds CLA32 one 32-bit chunk per cycle, LSW first, and carries c_o forward between chunks in a register.
- Returns the full-width sum and final carry over a second valid/ready handshake.

---
 rtl/cla_pkg.sv | 22 ++
 rtl/cla32.sv | 45 ++++
 rtl/cla_wide_add_seq.sv | 130 +++++++++++++
 tb/tb_cla_wide_add_seq.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the wide sequential adder built around the 32-bit CLA.
// Holds the chunk width, the controller state type and the counter-width helper.
package cla_pkg;

  localparam int CHUNK_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Chunk counter needs ceil(log2(words)) bits, never fewer than one.
  function automatic int cnt_width(input int words);
    if (words > 2) begin
      return $clog2(words);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/cla32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups whose group
// generate/propagate terms produce the carries between groups.
module cla32 (
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic        c_in,
  output logic [31:0] sum_o,
  output logic        c_o
);

  logic [31:0] g_s;
  logic [31:0] p_s;
  logic [31:0] c_s;
  logic [7:0]  grp_g_s;
  logic [7:0]  grp_p_s;
  logic [8:0]  grp_c_s;

  assign g_s        = a_in & b_in;
  assign p_s        = a_in ^ b_in;
  assign grp_c_s[0] = c_in;

  for (genvar j = 0; j < 8; j++) begin : g_grp
    localparam int B = 4 * j;

    // In-group carries are flattened so none depends on a neighbour bit's carry.
    assign c_s[B]   = grp_c_s[j];
    assign c_s[B+1] = g_s[B] | (p_s[B] & grp_c_s[j]);
    assign c_s[B+2] = g_s[B+1] | (p_s[B+1] & g_s[B])
                    | (p_s[B+1] & p_s[B] & grp_c_s[j]);
    assign c_s[B+3] = g_s[B+2] | (p_s[B+2] & g_s[B+1])
                    | (p_s[B+2] & p_s[B+1] & g_s[B])
                    | (p_s[B+2] & p_s[B+1] & p_s[B] & grp_c_s[j]);

    assign grp_g_s[j] = g_s[B+3] | (p_s[B+3] & g_s[B+2])
                      | (p_s[B+3] & p_s[B+2] & g_s[B+1])
                      | (p_s[B+3] & p_s[B+2] & p_s[B+1] & g_s[B]);
    assign grp_p_s[j] = p_s[B+3] & p_s[B+2] & p_s[B+1] & p_s[B];

    assign grp_c_s[j+1] = grp_g_s[j] | (grp_p_s[j] & grp_c_s[j]);
  end

  assign sum_o = p_s ^ c_s;
  assign c_o   = grp_c_s[8];

endmodule

// File: rtl/cla_wide_add_seq.sv
// Multi-cycle wide adder: latches WORDS x 32-bit operands and feeds one chunk
// per cycle, LSW first, through a single cla32, carrying between chunks in a register.
module cla_wide_add_seq
  import cla_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       in_valid_in,
  output logic                       in_ready_o,
  input  logic [CHUNK_W*WORDS-1:0]   a_in,
  input  logic [CHUNK_W*WORDS-1:0]   b_in,
  input  logic                       c_in,
  output logic                       out_valid_o,
  input  logic                       out_ready_in,
  output logic [CHUNK_W*WORDS-1:0]   sum_o,
  output logic                       c_o,
  output logic                       busy_o
);

  localparam int                 CNT_W    = cnt_width(WORDS);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WORDS - 1);

  state_e                        state_r;
  logic [CNT_W-1:0]              cnt_r;
  logic                          carry_r;
  logic [CHUNK_W*WORDS-1:0]      a_r;
  logic [CHUNK_W*WORDS-1:0]      b_r;
  logic [CHUNK_W-1:0]            sum_words_r [WORDS];
  logic                          c_r;
  logic                          in_ready_r;
  logic                          out_valid_r;
  logic                          busy_r;

  logic [CHUNK_W-1:0]            a_words_s [WORDS];
  logic [CHUNK_W-1:0]            b_words_s [WORDS];
  logic [CHUNK_W-1:0]            a_chunk_s;
  logic [CHUNK_W-1:0]            b_chunk_s;
  logic [CHUNK_W-1:0]            cla_sum_s;
  logic                          cla_c_s;

  for (genvar k = 0; k < WORDS; k++) begin : g_words
    assign a_words_s[k]                  = a_r[k*CHUNK_W +: CHUNK_W];
    assign b_words_s[k]                  = b_r[k*CHUNK_W +: CHUNK_W];
    assign sum_o[k*CHUNK_W +: CHUNK_W]   = sum_words_r[k];
  end

  // Chunk select: the adder only ever sees latched operands, never the input ports.
  always_comb begin
    a_chunk_s = a_words_s[cnt_r];
    b_chunk_s = b_words_s[cnt_r];
  end

  cla32 u_cla32 (
    .a_in  (a_chunk_s),
    .b_in  (b_chunk_s),
    .c_in  (carry_r),
    .sum_o (cla_sum_s),
    .c_o   (cla_c_s)
  );

  // Controller, operand latches and per-chunk sum write-back.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      carry_r     <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      c_r         <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      for (int k = 0; k < WORDS; k++) begin
        sum_words_r[k] <= '0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid_in) begin
            a_r        <= a_in;
            b_r        <= b_in;
            carry_r    <= c_in;
            cnt_r      <= '0;
            state_r    <= ST_RUN;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_RUN: begin
          sum_words_r[cnt_r] <= cla_sum_s;
          carry_r            <= cla_c_s;
          // Counter parks on the last chunk; it only restarts on the next acceptance.
          if (cnt_r == LAST_CNT) begin
            c_r         <= cla_c_s;
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            cnt_r       <= cnt_r + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready_in) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r     <= ST_DONE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_r;
  assign out_valid_o = out_valid_r;
  assign busy_o      = busy_r;
  assign c_o         = c_r;

endmodule

// File: tb/tb_cla_wide_add_seq.sv
// Scoreboard bench for cla_wide_add_seq: a driver pushes (a+b+c) expectations,
// a negedge monitor pops and compares on every output handshake.
module tb_cla_wide_add_seq;

  localparam int WORDS = 4;
  localparam int W     = 32 * WORDS;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           c_in = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   sum;
  logic           c_out;
  logic           busy;

  cla_wide_add_seq #(.WORDS(WORDS)) dut (
    .clk_in       (clk),
    .rst_n_in     (rst_n),
    .in_valid_in  (in_valid),
    .in_ready_o   (in_ready),
    .a_in         (a),
    .b_in         (b),
    .c_in         (c_in),
    .out_valid_o  (out_valid),
    .out_ready_in (out_ready),
    .sum_o        (sum),
    .c_o          (c_out),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W:0] exp_q [$];
  int         acc_q [$];
  int         rise_q [$];
  int         checks = 0;
  int         errors = 0;
  logic       prev_valid = 1'b0;
  logic       rand_done = 1'b0;

  task automatic chk_vec(input string name, input logic [W:0] act, input logic [W:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  // Monitor: latency on each rising out_valid, data on each output handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        rise_q.push_back(cyc);
        if (acc_q.size() > 0) begin
          int ac;
          ac = acc_q.pop_front();
          chk_int("latency", cyc - ac, WORDS);
        end else begin
          chk_int("unexpected_valid", 1, 0);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) begin
          logic [W:0] e;
          e = exp_q.pop_front();
          chk_vec("sum", {1'b0, sum}, {1'b0, e[W-1:0]});
          chk_int("carry", int'(c_out), int'(e[W]));
        end else begin
          chk_int("spurious_output", 1, 0);
        end
      end
      prev_valid = out_valid;
    end
  end

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] r;
    int mode;
    mode = $urandom_range(0, 5);
    for (int k = 0; k < WORDS; k++) r[k*32 +: 32] = $urandom;
    if (mode == 0) r = '1;
    else if (mode == 1) r = '0;
    else if (mode == 2) r[W-1:W/2] = '0;
    return r;
  endfunction

  // Present a request until accepted, then scramble the inputs.
  task automatic send(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic cc);
    logic ok;
    ok = 1'b0;
    @(posedge clk) #1;
    a = aa; b = bb; c_in = cc; in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, cc});
        acc_q.push_back(cyc + 1);
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk) #1;
    in_valid = 1'b0;
    a = rnd_word(); b = rnd_word(); c_in = 1'($urandom_range(0, 1));
    if (!ok) chk_int("accept_timeout", 0, 1);
  endtask

  task automatic drain(input int budget);
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) chk_int("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    logic [W-1:0] cap_sum;
    logic         cap_c;
    logic [W-1:0] ones;
    logic [W-1:0] ripple_a;
    logic [W-1:0] ripple_s;
    ones = '1;
    ripple_a = '0;
    ripple_a[95:0] = '1;
    ripple_s = '0;
    ripple_s[96] = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk_int("rst_in_ready", int'(in_ready), 1);
    chk_int("rst_out_valid", int'(out_valid), 0);
    chk_int("rst_busy", int'(busy), 0);
    chk_int("rst_c_o", int'(c_out), 0);
    chk_vec("rst_sum", {1'b0, sum}, '0);
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;

    send('0, '0, 1'b0);
    send(ripple_a, {{(W-1){1'b0}}, 1'b1}, 1'b0);
    chk_vec("ripple_model", exp_q[exp_q.size()-1], {1'b0, ripple_s});
    send(ones, ones, 1'b1);
    send(ones, ones, 1'b0);
    drain(200);

    // Backpressure: DONE holds its result; a new request is ignored.
    out_ready = 1'b0;
    send(rnd_word(), rnd_word(), 1'b1);
    for (int t = 0; t < 50 && !out_valid; t++) @(negedge clk);
    chk_int("bp_valid_seen", int'(out_valid), 1);
    cap_sum = sum;
    cap_c = c_out;
    a = rnd_word(); b = rnd_word(); in_valid = 1'b1;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk_int("bp_valid", int'(out_valid), 1);
      chk_int("bp_in_ready", int'(in_ready), 0);
      chk_int("bp_busy", int'(busy), 1);
      chk_vec("bp_sum_hold", {1'b0, sum}, {1'b0, cap_sum});
      chk_int("bp_c_hold", int'(c_out), int'(cap_c));
    end
    @(posedge clk) #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk) #1;
    chk_int("bp_idle_ready", int'(in_ready), 1);
    chk_int("bp_idle_valid", int'(out_valid), 0);
    chk_int("bp_idle_busy", int'(busy), 0);
    chk_vec("bp_sum_after", {1'b0, sum}, {1'b0, cap_sum});
    chk_int("bp_no_extra", exp_q.size(), 0);

    // Reset two RUN cycles into an operation.
    send(ones, ones, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_int("mid_rst_valid", int'(out_valid), 0);
    chk_int("mid_rst_c_o", int'(c_out), 0);
    chk_int("mid_rst_ready", int'(in_ready), 1);
    chk_vec("mid_rst_sum", {1'b0, sum}, '0);
    exp_q.delete();
    acc_q.delete();
    @(negedge clk) rst_n = 1'b1;
    send(W'(5), W'(3), 1'b0);
    chk_vec("post_rst_model", exp_q[0], (W+1)'(8));
    drain(200);

    // Back-to-back with out_ready tied high.
    repeat (3) @(negedge clk);
    rise_q.delete();
    send(rnd_word(), rnd_word(), 1'b0);
    send(rnd_word(), rnd_word(), 1'b1);
    drain(200);
    repeat (2) @(negedge clk);
    if (rise_q.size() >= 2) chk_int("b2b_interval", rise_q[1] - rise_q[0], WORDS + 2);
    else chk_int("b2b_rises", rise_q.size(), 2);

    // Random traffic with random consumer backpressure.
    fork
      begin
        while (!rand_done) begin
          @(posedge clk) #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int i = 0; i < 30; i++) send(rnd_word(), rnd_word(), 1'($urandom_range(0, 1)));
    drain(2000);
    rand_done = 1'b1;
    @(posedge clk) #2;
    out_ready = 1'b1;
    drain(200);
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
